// File: rtl/lb_poll_master_if.sv
// Local-bus poll frame TX request and RX response bundle.
// The master drives poll requests and consumes received frame info.
interface lb_poll_master_if;
    logic       poll_req;
    logic [7:0] poll_id;
    logic       poll_busy;
    logic       got_frame;
    logic [7:0] frame_id;
    logic [7:0] frame_type;
    logic       sn_error;

    modport master (
        output poll_req,
        output poll_id,
        input  poll_busy,
        input  got_frame,
        input  frame_id,
        input  frame_type,
        input  sn_error
    );

    modport slave (
        input  poll_req,
        input  poll_id,
        output poll_busy,
        output got_frame,
        output frame_id,
        output frame_type,
        output sn_error
    );
endinterface

// File: rtl/lb_poll_master.sv
// Station-side local-bus poller: walks card IDs, requests poll frames,
// times out responses and keeps a per-card online/miss record.
module lb_poll_master #(
    parameter int unsigned CARD_NUM    = 16,
    parameter int unsigned GAP_CYC     = 50,
    parameter int unsigned TIMEOUT_CYC = 2000,
    parameter int unsigned MAX_MISS    = 3,
    parameter logic [7:0]  RSP_TYPE    = 8'h02
) (
    input  logic                sys_clk,
    input  logic                glbl_rst_n,
    input  logic                init_done,
    input  logic                poll_en,
    lb_poll_master_if.master    bus,
    output logic [7:0]          id_now,
    output logic [CARD_NUM-1:0] card_online,
    output logic                timeout_pulse,
    output logic                cycle_done,
    output logic [15:0]         err_cnt
);

    typedef enum logic [2:0] {
        IDLE,
        GAP,
        REQ,
        WAIT_RSP,
        NEXT
    } state_t;

    localparam logic [7:0]  LAST_IDX = 8'(CARD_NUM - 1);
    localparam logic [15:0] GAP_END  = 16'(GAP_CYC - 1);
    localparam logic [15:0] TO_END   = 16'(TIMEOUT_CYC - 1);
    localparam logic [1:0]  MISS_MAX = 2'(MAX_MISS);

    state_t      state, state_nxt;
    logic [7:0]  idx, idx_nxt;
    logic [15:0] tmr, tmr_nxt;
    logic [1:0]  miss [CARD_NUM];

    logic rsp_ok;
    logic rsp_hit;
    logic to_hit;
    logic req_nxt;
    logic done_nxt;
    logic err_inc;

    assign rsp_ok = bus.got_frame
                 && (bus.frame_id == idx)
                 && (bus.frame_type == RSP_TYPE)
                 && !bus.sn_error;

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        tmr_nxt   = tmr;
        req_nxt   = 1'b0;
        done_nxt  = 1'b0;
        rsp_hit   = 1'b0;
        to_hit    = 1'b0;
        err_inc   = 1'b0;
        if (!init_done) begin
            // Losing init overrides any frame seen this cycle.
            state_nxt = IDLE;
            idx_nxt   = 8'd0;
        end else begin
            unique case (state)
                IDLE: begin
                    idx_nxt = 8'd0;
                    if (poll_en) begin
                        state_nxt = GAP;
                        tmr_nxt   = 16'd0;
                    end
                end
                GAP: begin
                    err_inc = bus.got_frame;
                    tmr_nxt = tmr + 16'd1;
                    if (tmr == GAP_END) begin
                        state_nxt = REQ;
                    end
                end
                REQ: begin
                    err_inc = bus.got_frame;
                    if (!bus.poll_busy) begin
                        req_nxt   = 1'b1;
                        tmr_nxt   = 16'd0;
                        state_nxt = WAIT_RSP;
                    end
                end
                WAIT_RSP: begin
                    if (rsp_ok) begin
                        rsp_hit   = 1'b1;
                        state_nxt = NEXT;
                    end else begin
                        err_inc = bus.got_frame;
                        // The window only runs while the transmitter is idle.
                        if (!bus.poll_busy) begin
                            if (tmr == TO_END) begin
                                to_hit    = 1'b1;
                                state_nxt = NEXT;
                            end else begin
                                tmr_nxt = tmr + 16'd1;
                            end
                        end
                    end
                end
                NEXT: begin
                    err_inc = bus.got_frame;
                    tmr_nxt = 16'd0;
                    if (idx == LAST_IDX) begin
                        idx_nxt   = 8'd0;
                        done_nxt  = 1'b1;
                        state_nxt = poll_en ? GAP : IDLE;
                    end else begin
                        idx_nxt   = idx + 8'd1;
                        state_nxt = GAP;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    idx_nxt   = 8'd0;
                end
            endcase
        end
    end

    always_ff @(posedge sys_clk or negedge glbl_rst_n) begin
        if (!glbl_rst_n) begin
            state         <= IDLE;
            idx           <= 8'd0;
            tmr           <= 16'd0;
            bus.poll_req  <= 1'b0;
            bus.poll_id   <= 8'd0;
            id_now        <= 8'hFF;
            card_online   <= '0;
            timeout_pulse <= 1'b0;
            cycle_done    <= 1'b0;
            err_cnt       <= 16'd0;
            for (int i = 0; i < int'(CARD_NUM); i++) begin
                miss[i] <= 2'd0;
            end
        end else begin
            state         <= state_nxt;
            idx           <= idx_nxt;
            tmr           <= tmr_nxt;
            bus.poll_req  <= req_nxt;
            timeout_pulse <= to_hit;
            cycle_done    <= done_nxt;
            id_now        <= (state_nxt == IDLE) ? 8'hFF : idx_nxt;
            if (req_nxt) begin
                bus.poll_id <= idx;
            end
            if (err_inc && (err_cnt != 16'hFFFF)) begin
                err_cnt <= err_cnt + 16'd1;
            end
            for (int i = 0; i < int'(CARD_NUM); i++) begin
                if (idx == 8'(i)) begin
                    if (rsp_hit) begin
                        miss[i]        <= 2'd0;
                        card_online[i] <= 1'b1;
                    end else if (to_hit) begin
                        if (miss[i] != MISS_MAX) begin
                            miss[i] <= miss[i] + 2'd1;
                        end
                        // Offline once the saturated count reaches the limit.
                        if ((miss[i] == MISS_MAX)
                            || (miss[i] == MISS_MAX - 2'd1)) begin
                            card_online[i] <= 1'b0;
                        end
                    end
                end
            end
        end
    end

endmodule
